// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int BRK = 2;
    localparam int FE  = 1;
    localparam int PE  = 0;

    localparam int MAX_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_e;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } rx_char_t;

    // Character length on the wire: start + data + optional parity + one stop.
    function automatic logic [3:0] frame_bits(input logic [1:0] data_bits, input logic parity_en);
        return 4'd7 + {2'b00, data_bits} + {3'b000, parity_en};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with level output and flush.
module uart_sync_fifo #(
    parameter int  WIDTH = 11,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    // Read side: rd_data_o is the head while valid_o=1; rd_en_i pops it, and is ignored when empty.
    assign valid_o   = (r_level != '0);
    assign full_o    = (r_level == (AW+1)'(DEPTH));
    assign w_pop     = rd_en_i && valid_o;
    assign w_push    = wr_en_i && (!full_o || w_pop);
    assign rd_data_o = valid_o ? r_mem[r_rptr] : '0;
    assign level_o   = r_level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) r_mem[r_wptr] <= wr_data_i;
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16550-class UART receiver: synchroniser, oversampling deserialiser, RX FIFO with
// per-character error flags, plus trigger, timeout and overrun indications.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int  FIFO_DEPTH    = 16,
    parameter int  OVERSAMPLE    = 16,
    parameter int  SYNC_STAGES   = 2,
    parameter int  TIMEOUT_CHARS = 4,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          baud_tick_i,
    input  logic          rx_i,
    input  logic          en_i,
    input  logic [1:0]    data_bits_i,
    input  logic          parity_en_i,
    input  logic          parity_even_i,
    input  logic          fifo_clr_i,
    input  logic [LW-1:0] trig_lvl_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic [2:0]    rd_err_o,
    output logic          rd_valid_o,
    output logic [LW-1:0] level_o,
    output logic          trig_o,
    output logic          timeout_o,
    output logic          overrun_o,
    input  logic          ovr_clr_i,
    output logic          busy_o
);

    localparam int CW     = $clog2(OVERSAMPLE);
    localparam int TO_MAX = TIMEOUT_CHARS * MAX_FRAME_BITS * OVERSAMPLE;
    localparam int TW     = $clog2(TO_MAX + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    rx_state_e              r_state;
    rx_state_e              w_next_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_data;
    logic                   r_pe;
    logic                   r_par_bit;
    data_bits_e             r_nbits;
    logic                   r_par_en;
    logic                   r_par_even;
    logic                   w_at_sample;
    logic                   w_last_bit;
    logic                   w_brk_now;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    rx_char_t               w_wr_char;
    rx_char_t               w_rd_char;
    logic                   w_full;
    logic                   w_valid;
    logic [LW-1:0]          w_level;
    logic                   r_ovr;
    logic [TW-1:0]          r_to_cnt;
    logic [TW-1:0]          w_to_limit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= rx_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // The start bit is re-checked half a bit in; every later sample is a full bit apart.
    assign w_at_sample = (r_state == ST_START) ? (r_cnt == CW'(OVERSAMPLE/2 - 1))
                                               : (r_cnt == CW'(OVERSAMPLE - 1));
    assign w_last_bit  = (r_bit == ({1'b0, r_nbits} + 3'd4));
    assign w_brk_now   = !w_rx_s && (r_data == 8'h00) && !(r_par_en && r_par_bit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (!en_i) begin
            w_next_state = ST_IDLE;
        end else if (baud_tick_i) begin
            case (r_state)
                ST_IDLE:     if (!w_rx_s) w_next_state = ST_START;
                ST_START:    if (w_at_sample) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:     if (w_at_sample && w_last_bit)
                                 w_next_state = r_par_en ? ST_PARITY : ST_STOP;
                ST_PARITY:   if (w_at_sample) w_next_state = ST_STOP;
                ST_STOP:     if (w_at_sample) w_next_state = w_brk_now ? ST_BRK_WAIT : ST_IDLE;
                ST_BRK_WAIT: if (w_rx_s) w_next_state = ST_IDLE;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o                 = (r_state != ST_IDLE);
        w_push                 = en_i && baud_tick_i && (r_state == ST_STOP) && w_at_sample;
        w_wr_char              = '0;
        w_wr_char.data         = w_brk_now ? 8'h00 : r_data;
        w_wr_char.err[BRK]     = w_brk_now;
        w_wr_char.err[FE]      = !w_rx_s;
        w_wr_char.err[PE]      = r_pe;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_pe       <= 1'b0;
            r_par_bit  <= 1'b0;
            r_nbits    <= DB_5;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
        end else if (en_i && baud_tick_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_data     <= '0;
                        r_pe       <= 1'b0;
                        r_par_bit  <= 1'b0;
                        r_nbits    <= data_bits_e'(data_bits_i);
                        r_par_en   <= parity_en_i;
                        r_par_even <= parity_even_i;
                    end
                end
                ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                    if (w_at_sample) begin
                        r_cnt <= '0;
                        if (r_state == ST_DATA) begin
                            r_data[r_bit] <= w_rx_s;
                            r_bit         <= r_bit + 3'd1;
                        end
                        if (r_state == ST_PARITY) begin
                            r_par_bit <= w_rx_s;
                            r_pe      <= (^r_data) ^ w_rx_s ^ ~r_par_even;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_char_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (fifo_clr_i),
        .wr_en_i   (w_push),
        .wr_data_i (w_wr_char),
        .rd_en_i   (rd_en_i),
        .rd_data_o (w_rd_char),
        .valid_o   (w_valid),
        .full_o    (w_full),
        .level_o   (w_level)
    );

    assign w_pop  = rd_en_i && w_valid;
    assign w_drop = w_push && w_full && !rd_en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          r_ovr <= 1'b0;
        else if (w_drop)    r_ovr <= 1'b1;
        else if (ovr_clr_i) r_ovr <= 1'b0;
    end

    assign w_to_limit = TW'(TIMEOUT_CHARS * OVERSAMPLE) * TW'(frame_bits(data_bits_i, parity_en_i));

    // Saturates at the limit so timeout_o stays up until FIFO activity restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                   r_to_cnt <= '0;
        else if (fifo_clr_i || w_push || w_pop)      r_to_cnt <= '0;
        else if (baud_tick_i && w_valid && (r_to_cnt < w_to_limit))
                                                     r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign rd_data_o  = w_rd_char.data;
    assign rd_err_o   = w_rd_char.err;
    assign rd_valid_o = w_valid;
    assign level_o    = w_level;
    assign trig_o     = w_valid && (w_level >= trig_lvl_i);
    assign timeout_o  = (r_to_cnt >= w_to_limit);
    assign overrun_o  = r_ovr;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised 16550-class UART receiver and the successor to the first-generation UART's receive path. It synchronises rx_i, oversamples it using an external baud tick, and deserialises 5–8 data bits with optional parity. Each character is pushed into a first-word-fall-through RX FIFO together with per-character error flags. The block raises trigger-level, timeout and overrun indications for the register/interrupt front end, which owns the RHR/LSR/IIR decode.

Parameters:
FIFO_DEPTH, 16, RX FIFO entries; must be a power of two, ≥2.
OVERSAMPLE, 16, baud ticks per bit; must be even, ≥4.
SYNC_STAGES, 2, flops in the rx_i synchroniser.
TIMEOUT_CHARS, 4, idle character times before timeout_o asserts.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
baud_tick_i  in  1  one-cycle pulse at OVERSAMPLE × baud rate, from the divisor/prescaler block
rx_i  in  1  serial input; asynchronous; idle high
en_i  in  1  receiver enable
data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits (LCR[1:0])
parity_en_i  in  1  parity bit present (LCR[3])
parity_even_i  in  1  1=even parity, 0=odd parity (LCR[4])
fifo_clr_i  in  1  synchronous FIFO flush (FCR[1])
trig_lvl_i  in  $clog2(FIFO_DEPTH)+1  trigger threshold
rd_en_i  in  1  pop head entry
rd_data_o  out  8  head data; upper unused bits are 0
rd_err_o  out  3  head flags {break, framing, parity}
rd_valid_o  out  1  FIFO not empty
level_o  out  $clog2(FIFO_DEPTH)+1  current entry count
trig_o  out  1  high when level_o ≥ trig_lvl_i and level_o ≠ 0
timeout_o  out  1  character-timeout indication
overrun_o  out  1  sticky overrun flag
ovr_clr_i  in  1  clears overrun_o (issued on LSR read)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: every output is 0, FSM is in IDLE, pointers and counters are 0, and the synchroniser flops preset to 1.
- rx_s is rx_i after SYNC_STAGES flops. All sample counting advances only on baud_tick_i.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE → START when rx_s=0 on a tick. The sample counter is cleared on this transition.
- START: at tick count OVERSAMPLE/2−1, a sample of rx_s=1 is a false start and the FSM returns to IDLE with no push. A sample of 0 moves the FSM to DATA with the counter cleared.
- Later bits are sampled every OVERSAMPLE ticks, which lands mid-bit.
- DATA: shifts LSB first for N bits. After N bits the FSM goes to PARITY if parity_en_i=1, otherwise to STOP.
- PARITY: the parity error flag is set when the XOR of the data bits and the parity bit does not equal (parity_even_i ? 0 : 1).
- STOP: only one stop bit is checked.
  - A stop sample of 0 sets the framing flag.
  - If the stop sample is 0, all data bits are 0 and the parity bit (if present) is 0, the break flag is also set, data is forced to 0x00, and the FSM goes to BRK_WAIT.
  - Otherwise the FSM returns to IDLE.
  - Push happens in the same clock as the stop sample.
- BRK_WAIT: stays until rx_s=1 on a tick, then returns to IDLE. Exactly one entry is pushed per break.
- en_i=0: the FSM goes to IDLE on the next clock and the partial frame is discarded. The FIFO is untouched.
- Configuration inputs are sampled only in IDLE → START and held for the whole frame.
- FIFO behaviour:
  - FWFT: rd_data_o and rd_err_o show the head combinationally while rd_valid_o=1, and are 0 when empty.
  - Pop on an empty FIFO is ignored.
  - Push on a full FIFO with no pop: the character is dropped, contents are unchanged and overrun_o sets the next cycle.
  - Push and pop in the same cycle when full: both take effect, level is unchanged and there is no overrun.
  - Push and pop in the same cycle when empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_clr_i empties the FIFO on the next clock, does not abort the frame in progress, and takes priority over a same-cycle push or pop.
- overrun_o: set has priority over a same-cycle ovr_clr_i.
- Timeout counter:
  - Counts ticks while level_o≠0 and there has been no push or pop.
  - Clears on any push, pop or fifo_clr_i.
  - timeout_o asserts when the count reaches TIMEOUT_CHARS × (2 + N + parity_en_i) × OVERSAMPLE.
  - timeout_o holds until the counter is cleared.
- Latency: rd_valid_o rises 1 clock after the stop-bit sample tick.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_e
  - err_idx constants: BRK=2, FE=1, PE=0
  - the data_bits encoding enum
  - the rx_char_t struct {err[2:0], data[7:0]}
- One sub-module, uart_sync_fifo: parametrised WIDTH and DEPTH, FWFT, providing level and clear. The TX path will reuse it.

Test Plan:
- 8N1 0xA5, OVERSAMPLE=16, tick every clock → rd_data_o=0xA5, rd_err_o=000 and level_o=1, with rd_valid_o rising 1 clock after the stop sample.
- 7E1 0x41 with the parity bit flipped → rd_data_o=0x41, rd_err_o=001. A following 5O1 0x1F with a correct parity bit → rd_data_o=0x1F, rd_err_o=000.
- rx held low for 3 frame times, then released → exactly one entry 0x00 with rd_err_o=110, followed by busy_o=0.
- A 7-tick low glitch → no push and busy_o back to 0 by tick 8. A stop bit driven 0 with nonzero data 0x3C → rd_err_o=010.
- 17 characters with no pops at FIFO_DEPTH=16 → level_o=16, overrun_o=1 and the 17th character dropped; ovr_clr_i clears the flag. A push plus pop while full → level_o stays 16 and overrun_o stays 0.
- 2 characters, then idle with trig_lvl_i=4 → trig_o=0; timeout_o asserts after 4×10×16 ticks (8N1) and clears on one rd_en_i. rst_i mid-frame → all outputs 0 and no push.
